pcw_ram_loader: RTL and testbench
=================================

Name: pcw_ram_loader

Overview:
- Sequences and shares the single RAM write/address port between three requesters:
  - boot-ROM copy engine (internal), which restores the boot stub to address 0 after every reset;
  - HPS ioctl ROM download;
  - the Z80 CPU.
- Holds the CPU in reset until a boot image is in RAM, then pulses execute_enable and hands the port to the CPU.
- Sits between hps_io, boot_loader and pcw_core in the top level.

Parameters:
BOOT_LEN, 276, number of boot-ROM bytes copied (addresses 0..BOOT_LEN-1)
ROM_INDEX, 0, ioctl_index value that selects a RAM-image download

Ports:
clk_sys  in  1  system clock (32 MHz)
reset  in  1  synchronous, active-high reset
rom_addr  out  16  boot_loader read address
rom_data  in  8  boot_loader data, valid the cycle after rom_addr is presented
ioctl_download  in  1  HPS download active
ioctl_index  in  8  download index
ioctl_wr  in  1  download byte strobe, single cycle
ioctl_addr  in  16  download byte address
ioctl_data  in  8  download byte
ioctl_wait  out  1  backpressure to hps_io
cpu_req  in  1  CPU memory request
cpu_we  in  1  CPU write enable, qualified by cpu_req
cpu_addr  in  16  CPU address
cpu_dout  in  8  CPU write data
cpu_wait  out  1  CPU stall; port not granted this cycle
ram_addr  out  16  shared RAM address
ram_din  out  8  shared RAM write data
ram_we  out  1  shared RAM write strobe
cpu_reset  out  1  hold CPU in reset
execute_enable  out  1  one-cycle pulse: start CPU at address 0
busy  out  1  loader owns RAM (states HOLD, READ, WRITE, DL)

Behaviour:
- Clocking and reset
  - Single clock clk_sys; reset synchronous active-high.
  - reset high forces state HOLD, count=0, buffer empty.
  - Outputs in HOLD: ram_we=0, execute_enable=0, cpu_reset=1, cpu_wait=1, ioctl_wait=0, busy=1, rom_addr=0.
- State machine: HOLD -> READ -> WRITE -> (READ | EXEC) -> RUN; DL reachable from READ, WRITE and RUN.
  - HOLD: first clock with reset low -> READ. This replaces the reset negative-edge detector.
  - READ: rom_addr=count, ram_we=0. Next state WRITE, unless the ioctl buffer owns the port this cycle; then stay in READ with rom_addr held.
  - WRITE: ram_addr=count, ram_din=rom_data, ram_we=1.
    - If count==BOOT_LEN-1 -> EXEC.
    - Else count<=count+1 -> READ.
    - Copy always wins in WRITE (rom_data is only valid there), so a pending ioctl byte waits one cycle.
    - Copy takes 2*BOOT_LEN cycles when uncontended.
  - EXEC: execute_enable=1 for exactly one cycle, cpu_reset=1 -> RUN.
  - RUN: cpu_reset=0. CPU is granted combinationally: ram_addr=cpu_addr, ram_din=cpu_dout, ram_we=cpu_req&cpu_we, cpu_wait=0.
  - DL: entered from any state other than HOLD/EXEC when ioctl_download=1 and ioctl_index==ROM_INDEX.
    - In DL: cpu_reset=1, cpu_wait=1, copy suspended.
    - On ioctl_download falling -> EXEC; the downloaded image replaces the boot stub, no re-copy.
    - Remains in DL while download stays high.
- ioctl byte buffer (one entry, all states except HOLD)
  - ioctl_wr with index==ROM_INDEX latches addr/data; buffer full next cycle.
  - ioctl_wait = buffer full.
  - Port priority: buffer > copy READ > CPU; copy WRITE > buffer.
  - When the buffer owns the port: ram_addr=buf_addr, ram_din=buf_data, ram_we=1, buffer empties that cycle. cpu_wait=1 if in RUN.
  - ioctl_wr while full: ignored. hps_io honours ioctl_wait, so this is a protocol error.
  - ioctl_wr arriving in the same cycle the buffer drains: accepted.
  - Writes with index!=ROM_INDEX: ignored, never waited.
- Boundaries
  - Reset mid-copy or mid-download: return to HOLD, then restart copy from count=0. Buffer contents discarded.
  - BOOT_LEN=1: READ, WRITE, EXEC.
  - count is 16 bits; no wrap, since BOOT_LEN<=65536.
  - execute_enable is never asserted twice without an intervening EXEC entry.

Test Plan:
- Reset 4 cycles then release -> ram_we pulses on every 2nd cycle for addresses 0..275 with ram_din=rom_data; execute_enable pulses at cycle 553 after release; cpu_reset falls at cycle 554.
- Re-assert reset when count=100 -> all outputs return to reset values; after release, copy restarts at address 0 and runs the full 276 bytes.
- In RUN, cpu_req=1, cpu_we=1, cpu_addr=0x1234, cpu_dout=0xA5 -> same cycle ram_we=1, ram_addr=0x1234, ram_din=0xA5, cpu_wait=0. With cpu_we=0 -> ram_we=0.
- In RUN, raise ioctl_download with index 0 and write bytes 0x11@0x0000, 0x22@0x0001 -> cpu_reset=1 and each byte is written to RAM. Lower download -> one execute_enable pulse, then RUN.
- ioctl_wr during copy at the cycle entering WRITE -> ioctl_wait=1 for 2 cycles, byte written in the following READ slot, and the copy address is neither skipped nor duplicated.
- ioctl_wr with index 3 (palette) in RUN -> no RAM write, ioctl_wait stays 0, cpu_wait stays 0.

Source files
------------

// File: rtl/pcw_ram_loader.sv
// -----------------------------------------------------------------------------
// pcw_ram_loader
//
// Owns the single RAM write/address port and shares it between three users:
// the internal boot-ROM copy engine, the HPS ioctl RAM-image download and the
// Z80 CPU. After every reset the boot stub is copied from boot_loader to RAM
// address 0. The CPU is then released with a one-cycle execute_enable pulse.
// A RAM-image download (ioctl_index == ROM_INDEX) holds the CPU in reset. It
// replaces the stub, and the CPU restarts when the download ends.
//
// Ports
//   clk_sys, reset        system clock, synchronous active-high reset
//   rom_addr / rom_data   boot_loader read port (data valid one cycle later)
//   ioctl_*               hps_io download interface, ioctl_wait = backpressure
//   cpu_*                 Z80 memory request, cpu_wait stalls the CPU
//   ram_addr/din/we       shared RAM write port
//   cpu_reset             holds the CPU in reset
//   execute_enable        one-cycle pulse: start CPU at address 0
//   busy                  loader owns the RAM (HOLD, READ, WRITE, DL)
// -----------------------------------------------------------------------------
module pcw_ram_loader #(
    parameter int         BOOT_LEN  = 276,
    parameter logic [7:0] ROM_INDEX = 8'd0
) (
    input  logic        clk_sys,
    input  logic        reset,

    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,

    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_wait,

    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,

    output logic        cpu_reset,
    output logic        execute_enable,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_READ,
        S_WRITE,
        S_EXEC,
        S_RUN,
        S_DL
    } state_t;

    localparam logic [15:0] LAST_ADDR = 16'(BOOT_LEN - 1);

    state_t      state;
    logic [15:0] count;

    // One-entry ioctl byte buffer
    logic        buf_full;
    logic [15:0] buf_addr;
    logic [7:0]  buf_data;

    logic        rom_index_hit;
    logic        dl_start;
    logic        buf_drain;
    logic        buf_accept;

    assign rom_index_hit = (ioctl_index == ROM_INDEX);
    assign dl_start      = ioctl_download && rom_index_hit;

    // The buffer has priority over the copy READ slot and over the CPU. It
    // never takes the copy WRITE slot, because rom_data is valid only there.
    assign buf_drain  = buf_full && (state != S_HOLD) && (state != S_WRITE);

    // A byte that arrives while the buffer drains refills it in the same cycle.
    assign buf_accept = ioctl_wr && rom_index_hit && (state != S_HOLD) &&
                        (!buf_full || buf_drain);

    // -------------------------------------------------------------------------
    // Sequencer and buffer-valid flag
    // -------------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments, so every
    // branch reads the values from the start of the cycle and the order of
    // the statements cannot change the result.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= S_HOLD;
            count    <= '0;
            buf_full <= 1'b0;
        end else begin
            case (state)
                // The first clock with reset low starts the copy.
                S_HOLD:  state <= S_READ;

                // A buffered ioctl byte takes this slot. Keep presenting the
                // same rom_addr so that the copy resumes without a gap.
                S_READ: begin
                    if (dl_start)        state <= S_DL;
                    else if (!buf_drain) state <= S_WRITE;
                end

                S_WRITE: begin
                    if (dl_start) begin
                        state <= S_DL;
                    end else if (count == LAST_ADDR) begin
                        state <= S_EXEC;
                    end else begin
                        count <= count + 16'd1;
                        state <= S_READ;
                    end
                end

                S_EXEC:  state <= S_RUN;

                S_RUN:   if (dl_start) state <= S_DL;

                // The downloaded image replaces the stub, so no re-copy.
                S_DL:    if (!ioctl_download) state <= S_EXEC;

                default: state <= S_HOLD;
            endcase

            if (buf_accept)     buf_full <= 1'b1;
            else if (buf_drain) buf_full <= 1'b0;
        end
    end

    // NOTE: the buffer payload has no reset. buf_full alone decides whether
    // the payload is meaningful, and leaving the data path unreset keeps it
    // off the reset tree.
    always_ff @(posedge clk_sys) begin
        if (buf_accept) begin
            buf_addr <= ioctl_addr;
            buf_data <= ioctl_data;
        end
    end

    // -------------------------------------------------------------------------
    // Shared RAM port multiplexer
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default before the priority chain. Without the
    // defaults, a path that does not assign an output would infer a latch.
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        cpu_wait = 1'b1;
        if (state == S_WRITE) begin
            ram_addr = count;
            ram_din  = rom_data;
            ram_we   = 1'b1;
        end else if (buf_drain) begin
            ram_addr = buf_addr;
            ram_din  = buf_data;
            ram_we   = 1'b1;
        end else if (state == S_RUN) begin
            ram_addr = cpu_addr;
            ram_din  = cpu_dout;
            ram_we   = cpu_req && cpu_we;
            cpu_wait = 1'b0;
        end
    end

    // count is 0 in HOLD, so rom_addr is 0 there as well.
    assign rom_addr       = count;
    assign ioctl_wait     = buf_full;
    assign cpu_reset      = (state != S_RUN);
    assign execute_enable = (state == S_EXEC);
    assign busy           = (state == S_HOLD) || (state == S_READ) ||
                            (state == S_WRITE) || (state == S_DL);

endmodule

// File: tb/tb_pcw_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_pcw_ram_loader
//
// Self-checking bench for pcw_ram_loader. A boot-ROM model feeds rom_data.
// A monitor keeps a shadow of everything written to RAM. The expected RAM
// image and the per-cycle port grants come from a transaction-level
// reference: the copy order and timing, the CPU grant rule, and the
// one-cycle buffer delay for ioctl bytes.
// -----------------------------------------------------------------------------
module tb_pcw_ram_loader;

    localparam int BOOT_LEN = 276;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        cpu_reset;
    logic        execute_enable;
    logic        busy;

    always #5 clk_sys = ~clk_sys;

    pcw_ram_loader #(.BOOT_LEN(BOOT_LEN), .ROM_INDEX(8'd0)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_dout       (cpu_dout),
        .cpu_wait       (cpu_wait),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .cpu_reset      (cpu_reset),
        .execute_enable (execute_enable),
        .busy           (busy)
    );

    // Boot ROM contents
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'd13;
        return t ^ a[15:8] ^ 8'h5A;
    endfunction

    // boot_loader model: data valid the cycle after the address
    always @(posedge clk_sys) rom_data <= rom_byte(rom_addr);

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // RAM write monitor
    typedef struct {
        int          c;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t      wq[$];
    bit [7:0] shadow  [65536];
    bit [7:0] exp_ram [65536];

    always @(negedge clk_sys) begin
        if (ram_we === 1'b1) begin
            shadow[ram_addr] = ram_din;
            wq.push_back('{cyc, ram_addr, ram_din});
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_sys);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ram_we"},    ram_we,         1'b0);
        check({tag, "_exec"},      execute_enable, 1'b0);
        check({tag, "_cpu_reset"}, cpu_reset,      1'b1);
        check({tag, "_cpu_wait"},  cpu_wait,       1'b1);
        check({tag, "_ioctl_wait"}, ioctl_wait,    1'b0);
        check({tag, "_busy"},      busy,           1'b1);
        check({tag, "_rom_addr"},  rom_addr,       16'h0000);
    endtask

    // Wait at negedges for execute_enable. Leaves time at that negedge.
    task automatic wait_ee(input string tag, input int limit, output int at);
        bit found;
        found = 0;
        at    = -1;
        for (int i = 0; i < limit; i++) begin
            sample();
            if (execute_enable === 1'b1) begin
                found = 1;
                at    = cyc;
                break;
            end
            tick();
        end
        check({tag, "_ee_seen"}, found, 1'b1);
    endtask

    // Copy writes must cover 0..BOOT_LEN-1 in order with ROM data, one every
    // second cycle. The timing shifts by one cycle after stall_after if an
    // ioctl byte took a READ slot.
    task automatic verify_copy(input string tag, input int rel, input int stall_after);
        int n;
        int bad;
        int exp_c;
        n   = 0;
        bad = 0;
        foreach (wq[i]) begin
            if (wq[i].a < 16'(BOOT_LEN)) begin
                exp_c = rel + 2 * n + 2 + ((stall_after >= 0 && n > stall_after) ? 1 : 0);
                if (wq[i].a != 16'(n) || wq[i].d != rom_byte(16'(n)) || wq[i].c != exp_c) bad++;
                n++;
            end
        end
        check({tag, "_count"}, n, BOOT_LEN);
        check({tag, "_seq"}, bad, 0);
        for (int i = 0; i < BOOT_LEN; i++) exp_ram[i] = rom_byte(16'(i));
    endtask

    // Transaction model for RUN. An accepted ioctl byte is written in the
    // next cycle and stalls the CPU there. Otherwise the CPU gets the port.
    bit          pend   = 0;
    logic [15:0] pend_a = '0;
    logic [7:0]  pend_d = '0;

    task automatic run_cycle(input logic req, input logic we, input logic [15:0] ca,
                             input logic [7:0] cd, input logic wr, input logic [7:0] idx,
                             input logic [15:0] wa, input logic [7:0] wd);
        tick();
        cpu_req = req; cpu_we = we; cpu_addr = ca; cpu_dout = cd;
        ioctl_wr = wr; ioctl_index = idx; ioctl_addr = wa; ioctl_data = wd;
        sample();
        if (pend) begin
            check("run_buf_we",    ram_we,     1'b1);
            check("run_buf_addr",  ram_addr,   pend_a);
            check("run_buf_din",   ram_din,    pend_d);
            check("run_buf_cwait", cpu_wait,   1'b1);
            check("run_buf_iwait", ioctl_wait, 1'b1);
            exp_ram[pend_a] = pend_d;
        end else begin
            check("run_cpu_we",    ram_we,     req & we);
            if (req & we) begin
                check("run_cpu_addr", ram_addr, ca);
                check("run_cpu_din",  ram_din,  cd);
                exp_ram[ca] = cd;
            end
            check("run_cpu_cwait", cpu_wait,   1'b0);
            check("run_cpu_iwait", ioctl_wait, 1'b0);
        end
        pend   = wr && (idx == 8'd0);
        pend_a = wa;
        pend_d = wd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          rel;
        int          at;
        int          bad;
        int          ee_cnt;
        bit          found;
        logic [15:0] dl_a [8];
        logic [7:0]  dl_d [8];
        logic [15:0] ca;
        logic [7:0]  cd;

        reset = 1'b1;
        ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_dout = '0;

        // Power-on reset
        repeat (4) tick();
        sample();
        check_reset("por");

        // First copy, aborted by reset at count 100
        tick();
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            sample();
            if (ram_we === 1'b1 && ram_addr == 16'd100) begin
                found = 1;
                break;
            end
            tick();
        end
        check("abort_reach_100", found, 1'b1);
        check("abort_din_100", ram_din, rom_byte(16'd100));
        tick();
        reset = 1'b1;
        tick();
        sample();
        check_reset("mid_copy");
        tick();
        check("abort_wr_count", wq.size(), 101);
        bad = 0;
        foreach (wq[i]) if (wq[i].a != 16'(i) || wq[i].d != rom_byte(16'(i))) bad++;
        check("abort_wr_seq", bad, 0);
        for (int i = 0; i <= 100; i++) exp_ram[i] = rom_byte(16'(i));
        wq.delete();

        // Full copy after release
        tick();
        reset = 1'b0;
        rel   = cyc;
        wait_ee("copy", 700, at);
        check("copy_ee_cycle", at - rel, 553);
        check("copy_ee_cpu_reset", cpu_reset, 1'b1);
        tick();
        sample();
        check("copy_run_cpu_reset", cpu_reset, 1'b0);
        check("copy_run_busy",      busy,      1'b0);
        check("copy_run_ee",        execute_enable, 1'b0);
        tick();
        verify_copy("copy", rel, -1);

        // RUN: directed CPU write, then read, then a foreign-index ioctl write
        run_cycle(1'b1, 1'b1, 16'h1234, 8'hA5, 1'b0, 8'd0, 16'h0, 8'h0);
        run_cycle(1'b1, 1'b0, 16'h1234, 8'hA5, 1'b0, 8'd0, 16'h0, 8'h0);
        run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'd3, 16'h4000, 8'h77);
        run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'd0, 16'h0, 8'h0);

        // RUN: random CPU traffic mixed with ioctl bytes of index 0 and 3
        for (int i = 0; i < 150; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'($urandom), 8'($urandom),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd3,
                      16'($urandom), 8'($urandom));
        end
        run_cycle(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 8'd0, 16'h0, 8'h0);

        // RAM-image download from RUN
        dl_a[0] = 16'h0000; dl_d[0] = 8'h11;
        dl_a[1] = 16'h0001; dl_d[1] = 8'h22;
        for (int i = 2; i < 8; i++) begin
            ca = 16'($urandom); cd = 8'($urandom);
            dl_a[i] = ca; dl_d[i] = cd;
        end
        tick();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        sample();
        tick();
        sample();
        check("dl_cpu_reset", cpu_reset, 1'b1);
        check("dl_cpu_wait",  cpu_wait,  1'b1);
        check("dl_busy",      busy,      1'b1);
        for (int k = 0; k < 8; k++) begin
            found = 0;
            for (int j = 0; j < 8; j++) begin
                if (ioctl_wait === 1'b0) begin
                    found = 1;
                    break;
                end
                tick();
                sample();
            end
            check("dl_wait_clear", found, 1'b1);
            tick();
            ioctl_wr = 1'b1; ioctl_addr = dl_a[k]; ioctl_data = dl_d[k];
            sample();
            check("dl_idle_we", ram_we, 1'b0);
            tick();
            ioctl_wr = 1'b0;
            sample();
            check("dl_we",        ram_we,     1'b1);
            check("dl_addr",      ram_addr,   dl_a[k]);
            check("dl_din",       ram_din,    dl_d[k]);
            check("dl_ioctl_wait", ioctl_wait, 1'b1);
            exp_ram[dl_a[k]] = dl_d[k];
        end
        tick();
        ioctl_download = 1'b0;
        sample();
        ee_cnt = (execute_enable === 1'b1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            sample();
            if (execute_enable === 1'b1) ee_cnt++;
        end
        check("dl_end_ee_pulses", ee_cnt, 1);
        check("dl_end_cpu_reset", cpu_reset, 1'b0);

        // Copy with an ioctl byte arriving on the edge into WRITE of byte 50
        tick();
        reset = 1'b1;
        repeat (2) tick();
        sample();
        check_reset("pre_contend");
        tick();
        wq.delete();
        reset = 1'b0;
        rel   = cyc;
        while (cyc < rel + 101) tick();
        ca = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        cd = 8'($urandom);
        ioctl_wr = 1'b1; ioctl_index = 8'd0; ioctl_addr = ca; ioctl_data = cd;
        tick();
        ioctl_wr = 1'b0;
        sample();
        check("contend_wait_1",   ioctl_wait, 1'b1);
        check("contend_copy_adr", ram_addr,   16'd50);
        tick();
        sample();
        check("contend_wait_2",   ioctl_wait, 1'b1);
        check("contend_buf_we",   ram_we,     1'b1);
        check("contend_buf_addr", ram_addr,   ca);
        check("contend_buf_din",  ram_din,    cd);
        tick();
        sample();
        check("contend_wait_off", ioctl_wait, 1'b0);
        tick();
        wait_ee("contend", 700, at);
        check("contend_ee_cycle", at - rel, 554);
        tick();
        sample();
        check("contend_run_cpu_reset", cpu_reset, 1'b0);
        tick();
        verify_copy("contend", rel, 50);
        bad   = 0;
        found = 0;
        foreach (wq[i]) begin
            if (wq[i].a >= 16'(BOOT_LEN)) begin
                if (found || wq[i].a != ca || wq[i].d != cd || wq[i].c != rel + 103) bad++;
                found = 1;
            end
        end
        check("contend_buf_write", bad, 0);
        check("contend_buf_seen",  found, 1'b1);
        exp_ram[ca] = cd;

        // Final RAM image against the reference
        bad = 0;
        for (int i = 0; i < 65536; i++) if (shadow[i] != exp_ram[i]) bad++;
        check("ram_image", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
